// File: rtl/disp_sched_pkg.sv
// Shared display-selector types: view encoding, mode encoding and counter sizing helper.
package common_types;

  localparam int unsigned DISP_NUM = 6;

  typedef enum logic [2:0] {
    CC    = 3'd0,
    PC    = 3'd1,
    ADDR  = 3'd2,
    OP    = 3'd3,
    INSTR = 3'd4,
    STATE = 3'd5
  } dispsel_t;

  typedef enum logic {
    AUTO   = 1'b0,
    MANUAL = 1'b1
  } disp_mode_t;

  // Width of a counter that runs 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_sched_key_debounce.sv
// Raw active-low KEY -> 2-flop synchroniser -> stability filter -> one-cycle press pulse.
module key_debounce
  import common_types::*;
#(
  parameter int unsigned DB_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES == 0) begin : g_bad_db
    $error("key_debounce: DB_CYCLES must be >= 1");
  end

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;

  // lvl changes only after the synchronised input has differed for DB_CYCLES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '1;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        lvl   <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_sched.sv
// 7-segment view sequencer: AUTO dwell rotation / MANUAL key stepping over enabled views.
// Optional post-change blanking enabled by defining DISP_SCHED_BLANK_EN.
module disp_sched
  import common_types::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DWELL_MS    = 1000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned BLANK_MS    = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                key_next,
  input  logic                key_mode,
  input  logic [DISP_NUM-1:0] en_mask,
  output dispsel_t            sel,
  output logic                auto_mode,
  output logic                adv,
  output logic                blank
);

  localparam int unsigned DWELL = CLK_HZ / 1000 * DWELL_MS;
  localparam int unsigned DB    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned BLANK = CLK_HZ / 1000 * BLANK_MS;
  localparam int unsigned DW    = cnt_width(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  if (DWELL == 0 || DB == 0 || BLANK == 0) begin : g_bad_cfg
    $error("disp_sched: DWELL, DB and BLANK cycle counts must be >= 1");
  end

  // Smallest upward offset wins because the loop visits offsets from largest to smallest.
  function automatic dispsel_t next_view(dispsel_t cur, logic [DISP_NUM-1:0] mask);
    dispsel_t    r;
    logic [2:0]  j;
    int unsigned c;
    r = cur;
    c = 32'(cur);
    for (int unsigned i = DISP_NUM - 1; i > 0; i--) begin
      j = 3'((c + i) % DISP_NUM);
      if (mask[j]) r = dispsel_t'(j);
    end
    return r;
  endfunction

  logic       next_press, mode_press;
  disp_mode_t mode, mode_n;
  dispsel_t   sel_n;
  logic [DW-1:0] cnt, cnt_n;
  logic       adv_n, step, run, blanking;

  key_debounce #(.DB_CYCLES(DB)) u_key_next (
    .clk(clk), .reset_n(reset_n), .key_n(key_next), .press(next_press)
  );
  key_debounce #(.DB_CYCLES(DB)) u_key_mode (
    .clk(clk), .reset_n(reset_n), .key_n(key_mode), .press(mode_press)
  );

  assign run = (mode == AUTO) && !blanking;

  always_comb begin
    mode_n = mode;
    sel_n  = sel;
    cnt_n  = cnt;
    adv_n  = 1'b0;
    step   = 1'b0;
    if (mode_press) begin
      mode_n = (mode == AUTO) ? MANUAL : AUTO;
      cnt_n  = '0;
    end
    if (en_mask == '0) begin
      sel_n = CC;
      cnt_n = '0;
    end else begin
      // disabled current view, key press and dwell expiry all collapse into one advance
      step = !en_mask[sel] || next_press || (run && cnt == DWELL_LAST);
      if (step) begin
        sel_n = next_view(sel, en_mask);
        adv_n = (sel_n != sel);
        cnt_n = '0;
      end else if (run && !mode_press) begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode <= AUTO;
      sel  <= CC;
      cnt  <= '0;
      adv  <= 1'b0;
    end else begin
      mode <= mode_n;
      sel  <= sel_n;
      cnt  <= cnt_n;
      adv  <= adv_n;
    end
  end

`ifdef DISP_SCHED_BLANK_EN
  localparam int unsigned BW = cnt_width(BLANK);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);
  logic [BW-1:0] bcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blanking <= 1'b0;
      bcnt     <= '0;
    end else if (adv_n) begin
      blanking <= 1'b1;
      bcnt     <= '0;
    end else if (blanking) begin
      if (bcnt == BLANK_LAST) blanking <= 1'b0;
      else                    bcnt     <= bcnt + 1'b1;
    end
  end
`else
  assign blanking = 1'b0;
`endif

  assign blank     = blanking;
  assign auto_mode = (mode == AUTO);

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched: expected advances queued by stimulus, checked on each adv pulse.
module tb_disp_sched;
  import common_types::*;

`ifdef DISP_SCHED_BLANK_EN
  localparam int GAP = 13;
`else
  localparam int GAP = 10;
`endif

  typedef struct {
    dispsel_t s;
    int       at;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       key_next = 1'b1;
  logic       key_mode = 1'b1;
  logic [5:0] en_mask = 6'h3F;
  dispsel_t   sel;
  logic       auto_mode, adv, blank;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   r;
  exp_t q[$];

  disp_sched #(
    .CLK_HZ(1000), .DWELL_MS(10), .DEBOUNCE_MS(2), .BLANK_MS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_next(key_next), .key_mode(key_mode),
    .en_mask(en_mask), .sel(sel), .auto_mode(auto_mode), .adv(adv), .blank(blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void expect_adv(input dispsel_t s, input int at);
    exp_t e;
    e.s  = s;
    e.at = at;
    q.push_back(e);
  endfunction

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next(input int hold);
    key_next = 1'b0;
    ncyc(hold);
    key_next = 1'b1;
  endtask

  // Monitor: every adv pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && adv) begin
      if (q.size() == 0) begin
        chk("unexpected_adv", 1, 0);
      end else begin
        e = q.pop_front();
        chk("adv_sel", int'(sel), int'(e.s));
        if (e.at >= 0) chk("adv_cycle", cyc, e.at);
`ifdef DISP_SCHED_BLANK_EN
        chk("blank_on_adv", int'(blank), 1);
`else
        chk("blank_tied_low", int'(blank), 0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("reset_sel", int'(sel), int'(CC));
    chk("reset_auto", int'(auto_mode), 1);
    chk("reset_adv", int'(adv), 0);
    chk("reset_blank", int'(blank), 0);

    // AUTO rotation through all six views including STATE -> CC wrap
    ncyc(2);
    reset_n = 1'b1;
    r = cyc;
    expect_adv(PC,    r + 10);
    expect_adv(ADDR,  r + 10 + GAP);
    expect_adv(OP,    r + 10 + 2 * GAP);
    expect_adv(INSTR, r + 10 + 3 * GAP);
    expect_adv(STATE, r + 10 + 4 * GAP);
    expect_adv(CC,    r + 10 + 5 * GAP);
    ncyc(10 + 5 * GAP + 2);
    chk("wrap_drained", q.size(), 0);
    chk("wrap_sel", int'(sel), int'(CC));

    // Mode key: glitch rejected, real press toggles (single view enabled -> no dwell advance)
    en_mask = 6'b000001;
    ncyc(1);
    key_mode = 1'b0;
    ncyc(1);
    key_mode = 1'b1;
    ncyc(8);
    chk("glitch_no_toggle", int'(auto_mode), 1);
    key_mode = 1'b0;
    ncyc(5);
    key_mode = 1'b1;
    ncyc(8);
    chk("mode_manual", int'(auto_mode), 0);

    en_mask = 6'h3F;
    ncyc(40);
    chk("manual_static", int'(sel), int'(CC));

    expect_adv(PC, -1);
    press_next(30);
    ncyc(6);
    chk("held_one_adv", q.size(), 0);
    chk("held_sel", int'(sel), int'(PC));

    // Sparse mask: disabled current view forces immediate advance
    en_mask = 6'b010101;
    expect_adv(ADDR, cyc + 1);
    ncyc(3);
    expect_adv(INSTR, -1);
    press_next(5);
    ncyc(6);
    expect_adv(CC, -1);
    press_next(5);
    ncyc(6);
    chk("sparse_sel", int'(sel), int'(CC));
    chk("sparse_drained", q.size(), 0);

    en_mask = 6'b000100;
    expect_adv(ADDR, cyc + 1);
    ncyc(3);
    en_mask = 6'b000000;
    ncyc(2);
    chk("zero_mask_sel", int'(sel), int'(CC));
    ncyc(15);
    chk("zero_mask_hold", int'(sel), int'(CC));
    chk("zero_mask_drained", q.size(), 0);

    // Async reset mid-dwell and mid-debounce
    en_mask = 6'h3F;
    reset_n = 1'b0;
    ncyc(2);
    reset_n = 1'b1;
    r = cyc;
    expect_adv(PC, r + 10);
    ncyc(15);
    key_next = 1'b0;
    ncyc(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_sel", int'(sel), int'(CC));
    chk("async_auto", int'(auto_mode), 1);
    chk("async_adv", int'(adv), 0);
    chk("async_blank", int'(blank), 0);
    key_next = 1'b1;
    ncyc(2);
    reset_n = 1'b1;
    r = cyc;
    expect_adv(PC, r + 10);
    ncyc(12);
    chk("post_reset_sel", int'(sel), int'(PC));
    chk("final_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
